// File: rtl/pipe_id_ex_reg_if.sv
// ---------------------------------------------------------------------------
// pipe_id_ex_reg_if
// Bundle of the ID->EX pipeline register signals. The ID stage, or the
// testbench standing in for it, drives the id_* fields and the stall/flush
// hazard controls. The pipeline register drives the ex_* fields.
//
// Modports
//   master : ID side. Drives id_*, stall and flush; reads ex_*.
//   slave  : pipeline register. Reads id_*, stall and flush; drives ex_*.
//
// Parameter
//   CTRL_W : width of the opaque control bundle carried from ID to EX.
// ---------------------------------------------------------------------------
interface pipe_id_ex_reg_if #(
    parameter int CTRL_W = 16
);
    logic              id_valid;
    logic [31:0]       id_instr;
    logic [31:0]       id_pc4;
    logic [31:0]       id_rs_data;
    logic [31:0]       id_rt_data;
    logic [4:0]        id_dst;
    logic [2:0]        id_imm_sel;
    logic [CTRL_W-1:0] id_ctrl;
    logic              stall;
    logic              flush;

    logic              ex_valid;
    logic [31:0]       ex_pc4;
    logic [31:0]       ex_rs_data;
    logic [31:0]       ex_rt_data;
    logic [31:0]       ex_imm;
    logic [4:0]        ex_dst;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [31:0]       ex_bta;

    modport master (
        output id_valid, id_instr, id_pc4, id_rs_data, id_rt_data,
               id_dst, id_imm_sel, id_ctrl, stall, flush,
        input  ex_valid, ex_pc4, ex_rs_data, ex_rt_data, ex_imm,
               ex_dst, ex_ctrl, ex_bta
    );

    modport slave (
        input  id_valid, id_instr, id_pc4, id_rs_data, id_rt_data,
               id_dst, id_imm_sel, id_ctrl, stall, flush,
        output ex_valid, ex_pc4, ex_rs_data, ex_rt_data, ex_imm,
               ex_dst, ex_ctrl, ex_bta
    );
endinterface

// File: rtl/pipe_id_ex_reg.sv
// ---------------------------------------------------------------------------
// pipe_id_ex_reg
// ID/EX pipeline register. It builds the 32-bit EX immediate from the ID
// instruction word and registers that immediate together with the operands,
// the destination register and the control bundle. Stall holds every EX-side
// register. Flush inserts a bubble and takes priority over stall.
//
// Ports
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : pipe_id_ex_reg_if.slave
//            inputs  id_valid, id_instr, id_pc4, id_rs_data, id_rt_data,
//                    id_dst, id_imm_sel, id_ctrl, stall, flush
//            outputs ex_valid, ex_pc4, ex_rs_data, ex_rt_data, ex_imm,
//                    ex_dst, ex_ctrl, ex_bta
//
// Parameters
//   CTRL_W  : control bundle width. It must match the interface CTRL_W.
//   RST_PC4 : value loaded into ex_pc4 on reset.
//
// Optional feature macro
//   PIPE_BTA_EN : when defined, ex_bta holds the registered value
//                 id_pc4 + (sign-extended imm16 << 2).
//                 When undefined, no adder is built and ex_bta is tied to 0.
// ---------------------------------------------------------------------------
module pipe_id_ex_reg #(
    parameter int          CTRL_W  = 16,
    parameter logic [31:0] RST_PC4 = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst_n,
    pipe_id_ex_reg_if.slave  bus
);

    // Immediate-select encodings.
    typedef enum logic [2:0] {
        IMM_ZERO16 = 3'd0,
        IMM_SIGN16 = 3'd1,
        IMM_SHAMT5 = 3'd2,
        IMM_BR18   = 3'd3,
        IMM_LUI    = 3'd4
    } imm_sel_e;

    logic [15:0] imm16;
    logic [4:0]  shamt;
    logic [31:0] br18_ext;
    logic [31:0] imm_next;

    assign imm16    = bus.id_instr[15:0];
    assign shamt    = bus.id_instr[10:6];
    assign br18_ext = {{14{imm16[15]}}, imm16, 2'b00};

    // Select the immediate in the ID stage. Unused encodings 5-7 give zero.
    always_comb begin
        imm_next = 32'b0;
        case (imm_sel_e'(bus.id_imm_sel))
            IMM_ZERO16: imm_next = {16'b0, imm16};
            IMM_SIGN16: imm_next = {{16{imm16[15]}}, imm16};
            IMM_SHAMT5: imm_next = {27'b0, shamt};
            IMM_BR18:   imm_next = br18_ext;
            IMM_LUI:    imm_next = {imm16, 16'b0};
            default:    imm_next = 32'b0;
        endcase
    end

    // The data registers load on a flush as well as on a normal advance.
    // After a flush their contents are don't-care, because ex_valid is low.
    logic load_data;
    assign load_data = bus.flush || !bus.stall;

    // Valid, destination and control registers. Flush wins over stall.
    // An invalid ID slot also loads zeros, so a bubble can never carry a
    // write-back or memory side effect into EX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ex_valid <= 1'b0;
            bus.ex_dst   <= 5'b0;
            bus.ex_ctrl  <= '0;
        end else if (bus.flush) begin
            bus.ex_valid <= 1'b0;
            bus.ex_dst   <= 5'b0;
            bus.ex_ctrl  <= '0;
        end else if (!bus.stall) begin
            bus.ex_valid <= bus.id_valid;
            bus.ex_dst   <= bus.id_valid ? bus.id_dst  : 5'b0;
            bus.ex_ctrl  <= bus.id_valid ? bus.id_ctrl : '0;
        end
    end

    // Data registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ex_pc4     <= RST_PC4;
            bus.ex_rs_data <= 32'b0;
            bus.ex_rt_data <= 32'b0;
            bus.ex_imm     <= 32'b0;
        end else if (load_data) begin
            bus.ex_pc4     <= bus.id_pc4;
            bus.ex_rs_data <= bus.id_rs_data;
            bus.ex_rt_data <= bus.id_rt_data;
            bus.ex_imm     <= imm_next;
        end
    end

`ifdef PIPE_BTA_EN
    // The branch target always uses the branch18 extension, whatever
    // id_imm_sel is. It follows the same load/hold rules as ex_pc4.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ex_bta <= 32'b0;
        end else if (load_data) begin
            bus.ex_bta <= bus.id_pc4 + br18_ext;
        end
    end
`else
    assign bus.ex_bta = 32'b0;
`endif

endmodule

// File: tb/tb_pipe_id_ex_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_id_ex_reg
// Scoreboard testbench for pipe_id_ex_reg.
//
// The driver works on the falling clock edge. Each cycle it applies one set of
// ID inputs, advances a reference model of the EX-side state, and pushes the
// expected state into a queue. A separate monitor runs 1 ns after every rising
// edge: it pops one expectation and compares it with the outputs. Data fields
// are compared only while the expected slot is valid, because they are
// don't-care inside a bubble.
//
// Defining PIPE_BTA_EN selects the expected branch-target behaviour.
// ---------------------------------------------------------------------------
module tb_pipe_id_ex_reg;

    localparam int CTRL_W = 16;

    typedef struct {
        logic              valid;
        logic [31:0]       pc4;
        logic [31:0]       rs;
        logic [31:0]       rt;
        logic [31:0]       imm;
        logic [4:0]        dst;
        logic [CTRL_W-1:0] ctrl;
        logic [31:0]       bta;
    } exp_t;

    logic clk;
    logic rst_n;

    pipe_id_ex_reg_if #(.CTRL_W(CTRL_W)) bus ();

    pipe_id_ex_reg #(.CTRL_W(CTRL_W), .RST_PC4(32'h0000_0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   compareCount  = 0;
    int   mismatchCount = 0;
    exp_t model;
    exp_t expQ[$];

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Zero-extend a 16-bit field into a 32-bit value.
    function automatic logic [31:0] u16(input logic [31:0] instr);
        return instr % 32'd65536;
    endfunction

    // Value of imm16 read as a signed number, kept modulo 2^32.
    function automatic logic [31:0] s16(input logic [31:0] instr);
        logic [31:0] v;
        v = u16(instr);
        if (v >= 32'd32768) return v - 32'd65536;
        return v;
    endfunction

    // Immediate built from its arithmetic definition.
    function automatic logic [31:0] immRef(input logic [31:0] instr, input int sel);
        case (sel)
            0:       return u16(instr);
            1:       return s16(instr);
            2:       return (instr / 32'd64) % 32'd32;
            3:       return s16(instr) * 32'd4;
            4:       return u16(instr) * 32'd65536;
            default: return 32'd0;
        endcase
    endfunction

    function automatic exp_t resetState();
        exp_t e;
        e.valid = 1'b0; e.pc4 = 32'h0; e.rs = 32'h0; e.rt = 32'h0;
        e.imm = 32'h0; e.dst = 5'h0; e.ctrl = '0; e.bta = 32'h0;
        return e;
    endfunction

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
        compareCount++;
        if (got !== want) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, got, want, $time);
        end
    endtask

    // Compare the DUT outputs with an expected state. When full is 0, the
    // data fields are checked only if the expected slot is valid.
    task automatic checkOutput(input exp_t e, input bit full);
        cmp("ex_valid", 32'(bus.ex_valid), 32'(e.valid));
        cmp("ex_ctrl",  32'(bus.ex_ctrl),  32'(e.ctrl));
        cmp("ex_dst",   32'(bus.ex_dst),   32'(e.dst));
        if (full || e.valid) begin
            cmp("ex_pc4",     bus.ex_pc4,     e.pc4);
            cmp("ex_rs_data", bus.ex_rs_data, e.rs);
            cmp("ex_rt_data", bus.ex_rt_data, e.rt);
            cmp("ex_imm",     bus.ex_imm,     e.imm);
            cmp("ex_bta",     bus.ex_bta,     e.bta);
        end
    endtask

    // Apply one cycle of ID inputs and push the state expected after the
    // next rising edge. Flush wins, stall freezes, otherwise the slot advances.
    task automatic applyStimulus(input logic v, input logic [31:0] instr,
                                 input logic [31:0] pc4, input logic [31:0] rs,
                                 input logic [31:0] rt, input logic [4:0] dst,
                                 input int sel, input logic [CTRL_W-1:0] ctrl,
                                 input logic st, input logic fl);
        @(negedge clk);
        bus.id_valid   = v;
        bus.id_instr   = instr;
        bus.id_pc4     = pc4;
        bus.id_rs_data = rs;
        bus.id_rt_data = rt;
        bus.id_dst     = dst;
        bus.id_imm_sel = 3'(sel);
        bus.id_ctrl    = ctrl;
        bus.stall      = st;
        bus.flush      = fl;
        if (fl || !st) begin
            model.pc4 = pc4;
            model.rs  = rs;
            model.rt  = rt;
            model.imm = immRef(instr, sel);
`ifdef PIPE_BTA_EN
            model.bta = pc4 + s16(instr) * 32'd4;
`else
            model.bta = 32'd0;
`endif
        end
        if (fl) begin
            model.valid = 1'b0;
        end else if (!st) begin
            model.valid = v;
        end
        if (fl || (!st && !v)) begin
            model.ctrl = '0;
            model.dst  = 5'd0;
        end else if (!st) begin
            model.ctrl = ctrl;
            model.dst  = dst;
        end
        expQ.push_back(model);
    endtask

    // Monitor: one expected state per rising edge while any are pending.
    always @(posedge clk) begin
        #1;
        if (rst_n && expQ.size() > 0) begin
            exp_t e;
            e = expQ.pop_front();
            checkOutput(e, 1'b0);
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] btaInstr;
        rst_n = 1'b0;
        bus.id_valid = 0; bus.id_instr = 0; bus.id_pc4 = 0; bus.id_rs_data = 0;
        bus.id_rt_data = 0; bus.id_dst = 0; bus.id_imm_sel = 0; bus.id_ctrl = '0;
        bus.stall = 0; bus.flush = 0;
        model = resetState();
        #3;
        checkOutput(resetState(), 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Each immediate select, using imm16=8004 (shamt field 0) and 80C4 (shamt 3).
        for (int s = 0; s < 8; s++)
            applyStimulus(1'b1, 32'h1234_8004, 32'h10 + 32'(s), 32'hA0 + 32'(s),
                          32'hB0 + 32'(s), 5'(s + 1), s, 16'h0100 + 16'(s), 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h0000_80C4, 32'h44, 32'h1, 32'h2, 5'd3, 2, 16'h0003, 1'b0, 1'b0);

        // Load pc4=0x100, then stall for 3 cycles while the ID inputs change.
        applyStimulus(1'b1, 32'h0000_0010, 32'h100, 32'h11, 32'h22, 5'd7, 1, 16'h00AA, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, $urandom, $urandom, $urandom, $urandom, 5'(i + 20), 0,
                          16'hBEEF, 1'b1, 1'b0);

        // Async reset while stall is still asserted and ex_valid=1: the
        // outputs must clear before any further clock edge.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput(resetState(), 1'b1);
        model = resetState();
        @(negedge clk);
        rst_n = 1'b1;

        // Flush and stall on the same edge with a valid ID, then stall alone.
        applyStimulus(1'b1, 32'h0000_0001, 32'h200, 32'h5, 32'h6, 5'd9, 0, 16'h1234, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h0000_0002, 32'h204, 32'h7, 32'h8, 5'd10, 0, 16'h5678, 1'b1, 1'b1);
        applyStimulus(1'b1, 32'h0000_0003, 32'h208, 32'h9, 32'hA, 5'd11, 0, 16'h9ABC, 1'b1, 1'b0);

        // Invalid ID slot with nonzero ctrl and dst loads a clean bubble.
        applyStimulus(1'b0, 32'h0000_0004, 32'h20C, 32'hB, 32'hC, 5'd31, 0, 16'hFFFF, 1'b0, 1'b0);

        // Branch target with a negative offset: pc4=0x0040_0010, imm16=FFFF.
        btaInstr = 32'h1000_FFFF;
        applyStimulus(1'b1, btaInstr, 32'h0040_0010, 32'h0, 32'h0, 5'd1, 3, 16'h0001, 1'b0, 1'b0);
        applyStimulus(1'b1, btaInstr, 32'h0040_0010, 32'h0, 32'h0, 5'd1, 0, 16'h0001, 1'b0, 1'b0);

        // Random traffic.
        for (int i = 0; i < 400; i++)
            applyStimulus(($urandom % 4) != 0, $urandom, $urandom, $urandom, $urandom,
                          5'($urandom), int'($urandom % 8), 16'($urandom),
                          ($urandom % 5) == 0, ($urandom % 8) == 0);

        @(negedge clk);
        @(negedge clk);
        compareCount++;
        if (expQ.size() != 0) begin
            mismatchCount++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", expQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
